// File: rtl/uart_cmd_responder.sv
// UART byte-framed register responder: 0xAA addr data writes, 0xBB addr reads and answers one byte.
// RF strobes fire the cycle after the last frame byte; the response is held in TX_SEND while TX_BUSY is high.
module uart_cmd_responder #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] RX_P_DATA,
  input  logic                  RX_D_VALID,
  input  logic                  RX_ERR,
  output logic [DATA_WIDTH-1:0] TX_P_DATA,
  output logic                  TX_D_VALID,
  input  logic                  TX_BUSY,
  output logic [ADDR_WIDTH-1:0] RF_ADDR,
  output logic                  RF_WR_EN,
  output logic                  RF_RD_EN,
  output logic [DATA_WIDTH-1:0] RF_WR_DATA,
  input  logic [DATA_WIDTH-1:0] RF_RD_DATA,
  input  logic                  RF_RD_VALID,
  output logic [7:0]            DROP_CNT,
  output logic                  CMD_BUSY
);

  typedef enum logic [2:0] {
    IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, TX_SEND, TX_WAIT
  } state_t;

  localparam logic [DATA_WIDTH-1:0] CMD_WR   = DATA_WIDTH'(8'hAA);
  localparam logic [DATA_WIDTH-1:0] CMD_RD   = DATA_WIDTH'(8'hBB);
  localparam logic [DATA_WIDTH-1:0] RESP_OOR = DATA_WIDTH'(8'hEE);
  localparam logic [DATA_WIDTH-1:0] RESP_TMO = DATA_WIDTH'(8'hEF);

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  oor_q, oor_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] resp_q, resp_d;
  logic [3:0]            tmo_q, tmo_d;
  logic                  seen_q, seen_d;
  logic                  wr_en_q, wr_en_d;
  logic                  rd_en_q, rd_en_d;
  logic [7:0]            drop_q, drop_d;
  logic                  drop;
  logic                  tx_fire;
  logic                  rx_ok;
  logic                  addr_oor;

  assign rx_ok    = RX_D_VALID && !RX_ERR;
  assign addr_oor = (RX_P_DATA >> ADDR_WIDTH) != '0;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    oor_d   = oor_q;
    wdata_d = wdata_q;
    resp_d  = resp_q;
    tmo_d   = tmo_q;
    seen_d  = seen_q;
    wr_en_d = 1'b0;
    rd_en_d = 1'b0;
    drop    = 1'b0;
    tx_fire = 1'b0;
    // A corrupted byte abandons whatever frame or response is in flight.
    if (RX_D_VALID && RX_ERR) begin
      drop    = 1'b1;
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (rx_ok) begin
            if (RX_P_DATA == CMD_WR)      state_d = WR_ADDR;
            else if (RX_P_DATA == CMD_RD) state_d = RD_ADDR;
            else                          drop    = 1'b1;
          end
        end
        WR_ADDR: begin
          if (rx_ok) begin
            addr_d  = RX_P_DATA[ADDR_WIDTH-1:0];
            oor_d   = addr_oor;
            state_d = WR_DATA;
          end
        end
        WR_DATA: begin
          if (rx_ok) begin
            wdata_d = RX_P_DATA;
            wr_en_d = !oor_q;
            state_d = IDLE;
          end
        end
        RD_ADDR: begin
          if (rx_ok) begin
            addr_d = RX_P_DATA[ADDR_WIDTH-1:0];
            if (addr_oor) begin
              resp_d  = RESP_OOR;
              state_d = TX_SEND;
            end else begin
              rd_en_d = 1'b1;
              tmo_d   = '0;
              state_d = RD_WAIT;
            end
          end
        end
        RD_WAIT: begin
          drop = RX_D_VALID;
          if (RF_RD_VALID) begin
            resp_d  = RF_RD_DATA;
            state_d = TX_SEND;
          end else if (tmo_q == 4'd15) begin
            resp_d  = RESP_TMO;
            state_d = TX_SEND;
          end else begin
            tmo_d = tmo_q + 4'd1;
          end
        end
        TX_SEND: begin
          drop = RX_D_VALID;
          if (!TX_BUSY) begin
            tx_fire = 1'b1;
            seen_d  = 1'b0;
            state_d = TX_WAIT;
          end
        end
        TX_WAIT: begin
          drop = RX_D_VALID;
          if (TX_BUSY)     seen_d  = 1'b1;
          else if (seen_q) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
    drop_d = (drop && drop_q != 8'hFF) ? drop_q + 8'd1 : drop_q;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      addr_q  <= '0;
      oor_q   <= 1'b0;
      wdata_q <= '0;
      resp_q  <= '0;
      tmo_q   <= '0;
      seen_q  <= 1'b0;
      wr_en_q <= 1'b0;
      rd_en_q <= 1'b0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      oor_q   <= oor_d;
      wdata_q <= wdata_d;
      resp_q  <= resp_d;
      tmo_q   <= tmo_d;
      seen_q  <= seen_d;
      wr_en_q <= wr_en_d;
      rd_en_q <= rd_en_d;
      drop_q  <= drop_d;
    end
  end

  // Outputs are forced quiet combinationally so they read zero during the reset cycle itself.
  assign TX_D_VALID = tx_fire & ~RST;
  assign TX_P_DATA  = RST ? '0 : resp_q;
  assign RF_ADDR    = RST ? '0 : addr_q;
  assign RF_WR_DATA = RST ? '0 : wdata_q;
  assign RF_WR_EN   = wr_en_q & ~RST;
  assign RF_RD_EN   = rd_en_q & ~RST;
  assign DROP_CNT   = RST ? 8'd0 : drop_q;
  assign CMD_BUSY   = !RST && (state_q != IDLE);

endmodule
